// File: rtl/contador_pkg.sv
// contador_pkg: shared state encoding, BCD digit limits and prescaler sizing for the mm:ss countdown
package contador_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] MAX_UNIT = 4'd9;
    localparam logic [3:0] MAX_TENS = 4'd5;

    function automatic int presc_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit of a borrow-chained decrementer, wrapping 0 -> MAX
module bcd_digit_dec #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    assign borrow_out = borrow_in && digit == 4'd0;
    assign digit_next = !borrow_in ? digit : (digit == 4'd0 ? MAX : digit - 4'd1);

endmodule

// File: rtl/contador_mmss_param.sv
// contador_mmss_param: loadable BCD mm:ss countdown timer with pause, cancel and done pulse
module contador_mmss_param
    import contador_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cancel,
    input  logic [4*MIN_DIGITS-1:0] min_in,
    input  logic [3:0]              dsec_in,
    input  logic [3:0]              usec_in,
    output logic [4*MIN_DIGITS-1:0] min_out,
    output logic [3:0]              dsec_out,
    output logic [3:0]              usec_out,
    output logic                    running,
    output logic                    paused,
    output logic                    done,
    output logic                    zero,
    output logic                    err
);

    localparam int PW = presc_width(TICK_DIV);
    localparam int ND = MIN_DIGITS + 2;

    state_t          state, state_nx;
    logic [PW-1:0]   presc, presc_nx;
    logic [4*ND-1:0] cnt, cnt_nx, cnt_dec, preset;
    logic [ND:0]     borrow;
    logic            err_nx, done_nx, wrap, tick, preset_ok;

    assign preset = {min_in, dsec_in, usec_in};
    assign {min_out, dsec_out, usec_out} = cnt;
    assign zero    = cnt == '0;
    assign running = state == RUN;
    assign paused  = state == PAUSE;

    // Digit 0 is units of seconds, digit 1 tens of seconds, the rest minutes.
    assign borrow[0] = 1'b1;
    genvar i;
    for (i = 0; i < ND; i++) begin : g_dig
        bcd_digit_dec #(.MAX(i == 1 ? MAX_TENS : MAX_UNIT)) u_dig (
            .digit     (cnt[4*i+:4]),
            .borrow_in (borrow[i]),
            .digit_next(cnt_dec[4*i+:4]),
            .borrow_out(borrow[i+1])
        );
    end

    // A borrow out of the top digit means the count is zero; never decrement then.
    assign wrap = presc == PW'(TICK_DIV - 1);
    assign tick = state == RUN && wrap && !borrow[ND];

    always_comb begin
        preset_ok = dsec_in <= MAX_TENS && usec_in <= MAX_UNIT;
        for (int k = 0; k < MIN_DIGITS; k++)
            preset_ok = preset_ok && min_in[4*k+:4] <= MAX_UNIT;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        presc_nx = presc;
        err_nx   = err;
        done_nx  = 1'b0;
        if (cancel) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            presc_nx = '0;
            err_nx   = 1'b0;
        end else if (stop && state == RUN) begin
            state_nx = PAUSE;
        end else if (start && state == IDLE && !zero) begin
            state_nx = RUN;
            presc_nx = '0;
        end else if (start && state == PAUSE) begin
            state_nx = RUN;
        end else if (load && (state == IDLE || state == DONE)) begin
            state_nx = IDLE;
            cnt_nx   = preset_ok ? preset : cnt;
            err_nx   = !preset_ok;
        end else if (state == RUN) begin
            presc_nx = wrap ? '0 : presc + 1'b1;
            if (tick) begin
                cnt_nx   = cnt_dec;
                done_nx  = cnt_dec == '0;
                state_nx = cnt_dec == '0 ? DONE : RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            presc <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            presc <= presc_nx;
            err   <= err_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_contador_mmss_param.sv
// tb_contador_mmss_param: scoreboard bench against a seconds-count reference model
module tb_contador_mmss_param;

    localparam int MD = 2;
    localparam int TD = 4;

    typedef struct packed {
        logic [7:0] m;
        logic [3:0] d;
        logic [3:0] u;
        logic       run;
        logic       pau;
        logic       dn;
        logic       z;
        logic       er;
    } obs_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, cancel = 1'b0;
    logic [7:0] min_in = '0;
    logic [3:0] dsec_in = '0, usec_in = '0;
    logic [7:0] min_out;
    logic [3:0] dsec_out, usec_out;
    logic       running, paused, done, zero, err;

    int   checks = 0, errors = 0, cycle = 0;
    obs_t exp_q[$];

    // Reference: state 0 idle / 1 run / 2 pause / 3 done; count held as total seconds.
    int m_st = 0, m_secs = 0, m_pre = 0;
    bit m_err = 0, m_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    contador_mmss_param #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .stop(stop), .cancel(cancel),
        .min_in(min_in), .dsec_in(dsec_in), .usec_in(usec_in),
        .min_out(min_out), .dsec_out(dsec_out), .usec_out(usec_out),
        .running(running), .paused(paused), .done(done), .zero(zero), .err(err)
    );

    function automatic obs_t model_obs();
        obs_t o;
        int   mm, ss;
        mm    = m_secs / 60;
        ss    = m_secs % 60;
        o.m   = {4'(mm / 10), 4'(mm % 10)};
        o.d   = 4'(ss / 10);
        o.u   = 4'(ss % 10);
        o.run = m_st == 1;
        o.pau = m_st == 2;
        o.dn  = m_done;
        o.z   = m_secs == 0;
        o.er  = m_err;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {min_out, dsec_out, usec_out, running, paused, done, zero, err};
    endfunction

    function automatic void step(input bit ld, st, sp, cn, input logic [7:0] m, input logic [3:0] d, u);
        bit ok;
        m_done = 0;
        if (cn) begin
            m_st = 0; m_secs = 0; m_pre = 0; m_err = 0;
        end else if (sp && m_st == 1) begin
            m_st = 2;
        end else if (st && m_st == 0 && m_secs != 0) begin
            m_st = 1; m_pre = 0;
        end else if (st && m_st == 2) begin
            m_st = 1;
        end else if (ld && (m_st == 0 || m_st == 3)) begin
            ok = m[7:4] <= 9 && m[3:0] <= 9 && d <= 5 && u <= 9;
            if (ok) m_secs = (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(d) * 10 + int'(u);
            m_err = !ok;
            m_st  = 0;
        end else if (m_st == 1) begin
            if (m_pre == TD - 1) begin
                m_pre  = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_st = 3; m_done = 1;
                end
            end else begin
                m_pre++;
            end
        end
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cycle, got, want);
        end
    endtask

    task automatic cyc(input bit ld, st, sp, cn, input logic [7:0] m = 8'h00,
                       input logic [3:0] d = 4'h0, input logic [3:0] u = 4'h0);
        @(negedge clk);
        load = ld; start = st; stop = sp; cancel = cn;
        min_in = m; dsec_in = d; usec_in = u;
        step(ld, st, sp, cn, m, d, u);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        load = 0; start = 0; stop = 0; cancel = 0;
        #1;
        check("async_reset", dut_obs(), obs_t'{8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        m_st = 0; m_secs = 0; m_pre = 0; m_err = 0; m_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("scoreboard", dut_obs(), exp_q.pop_front());
    end

    initial begin
        #1;
        check("power_on_reset", dut_obs(), obs_t'{8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // 01:00 full countdown to done
        cyc(1, 0, 0, 0, 8'h01, 4'h0, 4'h0);
        cyc(0, 1, 0, 0);
        idle(60 * TD + 4);
        // 10:00 borrow through every digit
        cyc(1, 0, 0, 0, 8'h10, 4'h0, 4'h0);
        cyc(0, 1, 0, 0);
        idle(TD + 2);
        cyc(0, 0, 0, 1);
        // pause at prescaler 2 around 00:30
        cyc(1, 0, 0, 0, 8'h00, 4'h3, 4'h1);
        cyc(0, 1, 0, 0);
        idle(TD + 2);
        cyc(0, 0, 1, 0);
        idle(20);
        cyc(0, 1, 0, 0);
        idle(4);
        cyc(0, 0, 0, 1);
        // invalid then valid preset
        cyc(1, 0, 0, 0, 8'h00, 4'h6, 4'h0);
        cyc(1, 0, 0, 0, 8'h00, 4'h0, 4'h5);
        cyc(1, 0, 0, 0, 8'h1A, 4'h0, 4'h0);
        cyc(1, 0, 0, 0, 8'h00, 4'h0, 4'h5);
        // async reset mid-run at 03:17, then start is ignored
        cyc(1, 0, 0, 0, 8'h03, 4'h2, 4'h0);
        cyc(0, 1, 0, 0);
        idle(3 * TD);
        do_reset();
        cyc(0, 1, 0, 0);
        idle(6);
        // start with zero count, then cancel during run
        cyc(0, 1, 0, 0);
        idle(TD + 2);
        cyc(1, 0, 0, 0, 8'h00, 4'h5, 4'h0);
        cyc(0, 1, 0, 0);
        idle(5 * TD);
        cyc(0, 0, 0, 1);
        idle(TD + 2);

        for (int k = 0; k < 4000; k++) begin
            bit         ld, st, sp, cn;
            logic [7:0] m;
            logic [3:0] d, u;
            if ($urandom_range(0, 499) == 0) do_reset();
            cn = $urandom_range(0, 79) == 0;
            sp = $urandom_range(0, 24) == 0;
            st = $urandom_range(0, 7) == 0;
            ld = $urandom_range(0, 11) == 0;
            m  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {4'd0, 4'($urandom_range(0, 1))};
            d  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            u  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            cyc(ld, st, sp, cn, m, d, u);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_mmss_param.md
CONTADOR_MMSS_PARAM -- requirements
Module: contador_mmss_param

Interface
REQ-001 SHALL have parameter MIN_DIGITS, default 2: number of BCD minute digits (1..3).
REQ-002 SHALL have parameter TICK_DIV, default 1000: clk cycles per one-second tick (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port load  input  1  capture preset digits (honoured in IDLE/DONE only).
REQ-006 SHALL have port start  input  1  begin (IDLE) or resume (PAUSE) countdown.
REQ-007 SHALL have port stop  input  1  pause countdown (honoured in RUN only).
REQ-008 SHALL have port cancel  input  1  abort; clear count; return to IDLE.
REQ-009 SHALL have port min_in  input  4*MIN_DIGITS  preset minutes, BCD, LS digit in [3:0].
REQ-010 SHALL have ports dsec_in / usec_in  input  4 each  preset tens / units of seconds, BCD.
REQ-011 SHALL have ports min_out / dsec_out / usec_out  output  4*MIN_DIGITS / 4 / 4  current count, registered.
REQ-012 SHALL have ports running / paused  output  1 each  state==RUN / state==PAUSE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on reaching zero.
REQ-014 SHALL have ports zero / err  output  1 each  count==all-zero (level) / sticky invalid-preset flag.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE; command priority cancel > stop > start > load > tick.
REQ-016 load in IDLE/DONE SHALL capture presets if every digit <=9 and dsec_in<=5; DONE->IDLE; err cleared.
REQ-017 invalid load SHALL leave count unchanged, set err, keep state (DONE still ->IDLE).
REQ-018 start in IDLE with count nonzero SHALL enter RUN next cycle with prescaler cleared; with count zero SHALL be ignored (no done).
REQ-019 prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick asserts in the cycle it equals TICK_DIV-1; first decrement TICK_DIV cycles after RUN entry.
REQ-020 each tick SHALL decrement count by one second: usec 0->9 with borrow, dsec 0->5 with borrow, minute digits 0->9 with borrow chained LS to MS.
REQ-021 tick that yields all-zero count SHALL move RUN->DONE and pulse done that same edge-registered cycle (done high exactly one cycle, coincident with DONE entry).
REQ-022 stop in RUN SHALL enter PAUSE; a tick in the same cycle SHALL be suppressed; prescaler SHALL hold its value.
REQ-023 start in PAUSE SHALL return to RUN resuming prescaler from held value.
REQ-024 cancel in any state SHALL clear count and prescaler to 0 and enter IDLE; err cleared.
REQ-025 start/stop in DONE, load in RUN/PAUSE SHALL be ignored; count SHALL never decrement below zero.
REQ-026 zero SHALL be combinationally derived from registered count only; err SHALL persist until valid load, cancel or reset.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, count=0, prescaler=0, running=paused=done=err=0, zero=1.
REQ-028 reset mid-RUN/PAUSE SHALL discard count; first edge after release SHALL behave as IDLE.

Structure
REQ-029 state encoding, digit limits (9, 5) and prescaler width clog2(TICK_DIV) (min 1) SHALL live in shared package contador_pkg.
REQ-030 SHALL use one sub-module bcd_digit_dec (parameter MAX, inputs digit/borrow_in, outputs next digit/borrow_out), instantiated MIN_DIGITS+2 times.
REQ-031 implementation SHALL be synthesizable, single clock domain, no latches.

Verification (MIN_DIGITS=2, TICK_DIV=4)
REQ-032 load 01:00, start -> 00:59 four cycles after RUN entry; after 60 ticks done pulses once, zero=1, state DONE.
REQ-033 load 10:00, start, one tick -> 09:59 (borrow through all four digits).
REQ-034 RUN at 00:30, stop with prescaler=2, hold 20 cycles -> count 00:30 unchanged, paused=1; start -> 00:29 exactly 2 cycles after RUN re-entry.
REQ-035 load dsec_in=6 -> err=1, count unchanged; subsequent load 00:05 -> err=0, count 00:05.
REQ-036 rst_n low mid-RUN at 03:17 -> outputs 00:00, zero=1, running=0 without clock edge; start after release ignored.
REQ-037 start with count 00:00 in IDLE -> stays IDLE, done never asserts; cancel during RUN at 00:45 -> IDLE, 00:00, no done.
